axi4_lite_slave_regfile: RTL and testbench

//  AXI4-Lite responder: a bank of NUM_REGS 32-bit control/status registers.

---
 rtl/axi4_lite_slave_regfile_pkg.sv | 15 +
 rtl/axi4_lite_slave_regfile_if.sv | 36 +++
 rtl/axi4_lite_slave_regfile_strb_merge.sv | 15 +
 rtl/axi4_lite_slave_regfile.sv | 159 +++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_slave_regfile_pkg.sv
// Shared types and widths for the AXI4-Lite register-file responder.
package axil_pkg;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic { W_IDLE, W_RESP } wr_state_t;
  typedef enum logic { R_IDLE, R_DATA } rd_state_t;
endpackage

// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file responder.
interface axi4_lite_slave_regfile_if #(parameter int ADDR_W = 32);
  import axil_pkg::*;

  logic [ADDR_W-1:0]      S_AXI_AWADDR;
  logic                   S_AXI_AWVALID;
  logic                   S_AXI_AWREADY;
  logic [AXIL_DATA_W-1:0] S_AXI_WDATA;
  logic [AXIL_STRB_W-1:0] S_AXI_WSTRB;
  logic                   S_AXI_WVALID;
  logic                   S_AXI_WREADY;
  logic [1:0]             S_AXI_BRESP;
  logic                   S_AXI_BVALID;
  logic                   S_AXI_BREADY;
  logic [ADDR_W-1:0]      S_AXI_ARADDR;
  logic                   S_AXI_ARVALID;
  logic                   S_AXI_ARREADY;
  logic [AXIL_DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]             S_AXI_RRESP;
  logic                   S_AXI_RVALID;
  logic                   S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_slave_regfile_strb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise the old byte is kept.
module axil_strb_merge
  import axil_pkg::*;
#(
  parameter int STRB_W = AXIL_STRB_W
) (
  input  logic [STRB_W*8-1:0] old_i,
  input  logic [STRB_W*8-1:0] new_i,
  input  logic [STRB_W-1:0]   strb_i,
  output logic [STRB_W*8-1:0] merged_o
);
  for (genvar b = 0; b < STRB_W; b++) begin : g_lane
    assign merged_o[8*b +: 8] = strb_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
  end
endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register file: NUM_REGS x 32-bit registers, independent write/read FSMs.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi4_lite_slave_regfile
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  axi4_lite_slave_regfile_if.slave        s_axi,
  output logic [NUM_REGS*AXIL_DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]             reg_wr
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WA_W  = ADDR_W - 2;
`ifdef AXIL_SLV_DECERR_EN
  localparam resp_t OOR_RESP = DECERR;
`else
  localparam resp_t OOR_RESP = OKAY;
`endif

  function automatic logic in_range(input logic [WA_W-1:0] wa);
    return wa < WA_W'(NUM_REGS);
  endfunction

  wr_state_t              w_state_q;
  logic                   aw_held_q, w_held_q;
  logic [WA_W-1:0]        awaddr_q;
  logic [AXIL_DATA_W-1:0] wdata_q;
  logic [AXIL_STRB_W-1:0] wstrb_q;
  logic                   bvalid_q;
  resp_t                  bresp_q;
  rd_state_t              r_state_q;
  logic                   rvalid_q;
  resp_t                  rresp_q;
  logic [AXIL_DATA_W-1:0] rdata_q;
  logic [AXIL_DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    reg_wr_q;

  logic                   aw_hs, w_hs, commit, wr_ok, rd_ok;
  logic [WA_W-1:0]        wa_c, ra_c;
  logic [AXIL_DATA_W-1:0] wd_c, merged;
  logic [AXIL_STRB_W-1:0] ws_c;
  logic [IDX_W-1:0]       wr_idx, rd_idx;
  logic                   unused_addr_lsbs;

  assign s_axi.S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
  assign s_axi.S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_held_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = (r_state_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign unused_addr_lsbs    = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  // Commit once both halves are present, whether latched earlier or arriving now.
  assign commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wa_c   = aw_held_q ? awaddr_q : s_axi.S_AXI_AWADDR[ADDR_W-1:2];
  assign wd_c   = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
  assign ws_c   = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign wr_ok  = in_range(wa_c);
  assign wr_idx = wa_c[IDX_W-1:0];
  assign ra_c   = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
  assign rd_ok  = in_range(ra_c);
  assign rd_idx = ra_c[IDX_W-1:0];

  axil_strb_merge #(.STRB_W(AXIL_STRB_W)) u_merge (
    .old_i    (regs_q[wr_idx]),
    .new_i    (wd_c),
    .strb_i   (ws_c),
    .merged_o (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      reg_wr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      reg_wr_q <= '0;
      case (w_state_q)
        W_IDLE: begin
          if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? OKAY : OOR_RESP;
            w_state_q <= W_RESP;
            if (wr_ok) begin
              regs_q[wr_idx]   <= merged;
              reg_wr_q[wr_idx] <= 1'b1;
            end
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= s_axi.S_AXI_AWADDR[ADDR_W-1:2];
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= s_axi.S_AXI_WDATA;
              wstrb_q  <= s_axi.S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs_q before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi.S_AXI_ARVALID) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_ok ? regs_q[rd_idx] : '0;
            rresp_q   <= rd_ok ? OKAY : OOR_RESP;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[AXIL_DATA_W*i +: AXIL_DATA_W] = regs_q[i];
  end
  assign reg_wr = reg_wr_q;
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Randomized self-checking bench for axi4_lite_slave_regfile against a flat-array register model.
module tb_axi4_lite_slave_regfile;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 32;
  localparam int IW       = $clog2(NUM_REGS);
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] OOR = 2'b11;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0]    reg_wr;

  axi4_lite_slave_regfile_if #(.ADDR_W(ADDR_W)) bus ();

  axi4_lite_slave_regfile #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axi  (bus),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [31:0] mdl [NUM_REGS];

  function automatic bit mdl_in(input logic [31:0] addr);
    return (addr >> 2) < NUM_REGS;
  endfunction

  function automatic void mdl_write(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb);
    if (mdl_in(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[IW'(addr >> 2)][8*b +: 8] = data[8*b +: 8];
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] addr);
    return mdl_in(addr) ? mdl[IW'(addr >> 2)] : 32'h0;
  endfunction

  function automatic logic [NUM_REGS*32-1:0] mdl_flat();
    logic [NUM_REGS*32-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = mdl[i];
    return f;
  endfunction

  function automatic logic [NUM_REGS-1:0] mdl_pulse(input logic [31:0] addr);
    logic [NUM_REGS-1:0] p;
    p = '0;
    if (mdl_in(addr)) p[IW'(addr >> 2)] = 1'b1;
    return p;
  endfunction

  function automatic logic [1:0] mdl_resp(input logic [31:0] addr);
    return mdl_in(addr) ? 2'b00 : OOR;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] bresp, output logic [NUM_REGS-1:0] wr_seen,
                           output bit early, output bit bv_ok);
    bit aw_p, w_p, aw_h, w_h;
    int cyc;
    aw_p = 1; w_p = 1; cyc = 0; early = 0; bv_ok = 1;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    while ((aw_p || w_p) && cyc < 100) begin
      bus.S_AXI_AWVALID = aw_p && (cyc >= aw_dly);
      bus.S_AXI_WVALID  = w_p && (cyc >= w_dly);
      aw_h = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_h  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      if (bus.S_AXI_BVALID) early = 1;
      @(posedge clk); #1;
      if (aw_h) aw_p = 0;
      if (w_h)  w_p = 0;
      cyc++;
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    if (aw_p || w_p) bv_ok = 0;
    wr_seen = reg_wr;
    bresp   = bus.S_AXI_BRESP;
    if (!bus.S_AXI_BVALID) bv_ok = 0;
    repeat (b_dly) begin
      @(posedge clk); #1;
      if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== bresp || bus.S_AXI_AWREADY) bv_ok = 0;
    end
    bus.S_AXI_BREADY = 1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 0;
    if (bus.S_AXI_BVALID) bv_ok = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] rdata, output logic [1:0] rresp, output bit ok);
    int cyc;
    ok = 1; cyc = 0;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1;
    while (!bus.S_AXI_ARREADY && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 100) ok = 0;
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 0;
    if (!bus.S_AXI_RVALID) ok = 0;
    rdata = bus.S_AXI_RDATA; rresp = bus.S_AXI_RRESP;
    repeat (r_dly) begin
      if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== rdata || bus.S_AXI_RRESP !== rresp ||
          bus.S_AXI_ARREADY) ok = 0;
      @(posedge clk); #1;
    end
    bus.S_AXI_RREADY = 1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 0;
    if (bus.S_AXI_RVALID || !bus.S_AXI_ARREADY) ok = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (reg_q !== '0 || reg_wr !== '0) begin
      errs++; $display("FAIL reset_regs: reg_q=%0h reg_wr=%0h exp 0", reg_q, reg_wr);
    end
    vecs++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 6'b0 ||
        bus.S_AXI_RDATA !== 32'h0) begin
      errs++; $display("FAIL reset_resp: bv=%b rv=%b bresp=%b rresp=%b rdata=%h exp all 0",
                       bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP,
                       bus.S_AXI_RDATA);
    end
    rst_n = 1;
    @(posedge clk); #1;
    vecs++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
      errs++; $display("FAIL reset_ready: aw/w/ar ready=%b%b%b exp 111",
                       bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] br; logic [NUM_REGS-1:0] ws; bit early, bv;
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 1, br, ws, early, bv);
    mdl_write(32'h8, 32'hDEADBEEF, 4'hF);
    vecs++;
    if (bv !== 1'b1 || br !== 2'b00) begin
      errs++; $display("FAIL t1_bresp: bvalid_ok=%b bresp=%b exp 1/00", bv, br);
    end
    vecs++;
    if (ws !== mdl_pulse(32'h8)) begin
      errs++; $display("FAIL t1_reg_wr: got %0h exp %0h", ws, mdl_pulse(32'h8));
    end
    vecs++;
    if (reg_q[64 +: 32] !== 32'hDEADBEEF || reg_q !== mdl_flat()) begin
      errs++; $display("FAIL t1_reg2: got %h exp DEADBEEF", reg_q[64 +: 32]);
    end
    vecs++;
    if (reg_wr !== '0) begin
      errs++; $display("FAIL t1_pulse_width: reg_wr=%0h exp 0", reg_wr);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] br; logic [NUM_REGS-1:0] ws; bit early, bv;
    axi_write(32'h8, 32'h11223344, 4'h5, 3, 0, 2, br, ws, early, bv);
    mdl_write(32'h8, 32'h11223344, 4'h5);
    vecs++;
    if (early !== 1'b0 || bv !== 1'b1) begin
      errs++; $display("FAIL t2_bvalid_timing: early=%b bvalid_ok=%b exp 0/1", early, bv);
    end
    vecs++;
    if (reg_q[64 +: 32] !== 32'hDE22BE44 || reg_q !== mdl_flat()) begin
      errs++; $display("FAIL t2_merge: got %h exp DE22BE44", reg_q[64 +: 32]);
    end
  endtask

  task automatic test_read_hold();
    logic [31:0] rd; logic [1:0] rr; bit ok;
    axi_read(32'h8, 4, rd, rr, ok);
    vecs++;
    if (rd !== 32'hDE22BE44 || rr !== 2'b00) begin
      errs++; $display("FAIL t3_rdata: got %h/%b exp DE22BE44/00", rd, rr);
    end
    vecs++;
    if (ok !== 1'b1) begin
      errs++; $display("FAIL t3_hold: stability/ready ok=%b exp 1", ok);
    end
  endtask

  task automatic test_read_during_commit();
    logic [31:0] old_v;
    old_v = mdl_read(32'h8);
    bus.S_AXI_AWADDR = 32'h8; bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 32'h8;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_ARVALID = 1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    mdl_write(32'h8, 32'hCAFEF00D, 4'hF);
    vecs++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== old_v) begin
      errs++; $display("FAIL t4_old_value: rvalid=%b rdata=%h exp 1/%h",
                       bus.S_AXI_RVALID, bus.S_AXI_RDATA, old_v);
    end
    vecs++;
    if (reg_q[64 +: 32] !== 32'hCAFEF00D || bus.S_AXI_BVALID !== 1'b1) begin
      errs++; $display("FAIL t4_commit: reg2=%h bvalid=%b exp CAFEF00D/1",
                       reg_q[64 +: 32], bus.S_AXI_BVALID);
    end
    // Release R only; B must not hold it up.
    bus.S_AXI_RREADY = 1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 0;
    vecs++;
    if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_BVALID !== 1'b1) begin
      errs++; $display("FAIL t4_indep: rvalid=%b bvalid=%b exp 0/1",
                       bus.S_AXI_RVALID, bus.S_AXI_BVALID);
    end
    bus.S_AXI_BREADY = 1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 0;
  endtask

  task automatic test_out_of_range();
    logic [1:0] br, rr; logic [NUM_REGS-1:0] ws; bit early, bv, ok; logic [31:0] rd;
    logic [31:0] a;
    a = NUM_REGS * 4;
    axi_write(a, $urandom, 4'hF, 0, 1, 0, br, ws, early, bv);
    vecs++;
    if (br !== OOR || ws !== '0 || reg_q !== mdl_flat()) begin
      errs++; $display("FAIL t5_write: bresp=%b reg_wr=%0h exp %b/0, regs changed=%b",
                       br, ws, OOR, reg_q !== mdl_flat());
    end
    axi_read(a, 1, rd, rr, ok);
    vecs++;
    if (rd !== 32'h0 || rr !== OOR || ok !== 1'b1) begin
      errs++; $display("FAIL t5_read: rdata=%h rresp=%b ok=%b exp 0/%b/1", rd, rr, ok, OOR);
    end
  endtask

  task automatic test_random();
    logic [1:0] br, rr; logic [NUM_REGS-1:0] ws; bit early, bv, ok;
    logic [31:0] a, d, rd; logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, NUM_REGS) * 4) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  br, ws, early, bv);
        mdl_write(a, d, s);
        vecs++;
        if (br !== mdl_resp(a) || ws !== mdl_pulse(a) || early || !bv) begin
          errs++; $display("FAIL rnd_write a=%h: bresp=%b reg_wr=%0h early=%b bv=%b exp %b/%0h/0/1",
                           a, br, ws, early, bv, mdl_resp(a), mdl_pulse(a));
        end
        vecs++;
        if (reg_q !== mdl_flat()) begin
          errs++; $display("FAIL rnd_regs a=%h: got %h exp %h", a, reg_q, mdl_flat());
        end
      end else begin
        axi_read(a, $urandom_range(0, 3), rd, rr, ok);
        vecs++;
        if (rd !== mdl_read(a) || rr !== mdl_resp(a) || !ok) begin
          errs++; $display("FAIL rnd_read a=%h: rdata=%h rresp=%b ok=%b exp %h/%b/1",
                           a, rd, rr, ok, mdl_read(a), mdl_resp(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.S_AXI_AWADDR = 32'h4; bus.S_AXI_WDATA = 32'h5A5A5A5A; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    vecs++;
    if (bus.S_AXI_BVALID !== 1'b1) begin
      errs++; $display("FAIL t6_setup: bvalid=%b exp 1", bus.S_AXI_BVALID);
    end
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    vecs++;
    if (bus.S_AXI_BVALID !== 1'b0 || reg_q !== '0) begin
      errs++; $display("FAIL t6_async: bvalid=%b reg_q=%h exp 0/0", bus.S_AXI_BVALID, reg_q);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    vecs++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_BVALID !== 1'b0) begin
      errs++; $display("FAIL t6_release: awready=%b bvalid=%b exp 1/0",
                       bus.S_AXI_AWREADY, bus.S_AXI_BVALID);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_read_hold();
    test_read_during_commit();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
